load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage between the datapath and a handshaked memory port.
- Takes the address (ALUResult), store data and size/sign code (funct3) from the current instruction and issues a bus transaction.
- Stalls the core until the transaction completes.
- Returns the size-extracted, sign/zero-extended ReadData consumed by the writeback result select.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT_R before aborting with AccessErr; range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store; MemRead and MemWrite never both 1
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult  in  32  byte address
- WriteData  in  32  store data, rs2
- ReadData  out  32  registered, extended load result
- Stall  out  1  holds PC/regfile write while high
- AccessErr  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables, 0000 on reads
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, ≥1 cycle after gnt
- mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_wstrb=0; ReadData=0; AccessErr=0; timeout counter=0.
- States: IDLE, REQ, WAIT_R, DONE.
- Stall = (IDLE & (MemRead|MemWrite)) | REQ | WAIT_R. Stall is 0 in DONE, so the PC advances at the end of DONE.
- IDLE with an access:
  - Latch funct3, addr[1:0], we, wdata and strobes.
  - Legal and aligned: go to REQ.
  - Illegal funct3 (011, 110, 111 for loads; anything other than 000/001/010 for stores) or misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): go to DONE with the error flag set. No bus request is issued.
- REQ:
  - mem_req=1; outputs stay stable until mem_gnt.
  - Store with gnt: go to DONE.
  - Load with gnt: go to WAIT_R.
- WAIT_R:
  - mem_rvalid: ReadData <= extract(mem_rdata), go to DONE.
  - rvalid is sampled only in WAIT_R and ignored in every other state.
- DONE:
  - AccessErr=1 if the error flag is set.
  - Always returns to IDLE next cycle; it never re-launches the same instruction.
- Extraction:
  - B/BU: byte at addr[1:0], sign- or zero-extended.
  - H/HU: half at addr[1], sign- or zero-extended.
  - W: whole word.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = 0011<<(2*addr[1]), wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = WriteData.
- Timeout:
  - Counter clears on leaving IDLE and increments each cycle in REQ/WAIT_R.
  - On reaching TIMEOUT_CYCLES: drop mem_req, go to DONE with AccessErr; ReadData unchanged.
- ReadData changes only on a successful load capture; errors and stores leave it unchanged.
- Minimum latency, zero-wait memory: store 3 cycles (IDLE→REQ→DONE); load 4 cycles (IDLE→REQ→WAIT_R→DONE).
- Reset mid-operation: return to IDLE and drop mem_req the same edge; a later stray rvalid is ignored.

Test Plan:
- LW addr 0x100, gnt on first REQ cycle, rvalid 2 cycles later with rdata 0xDEADBEEF → mem_addr 0x100, ReadData=0xDEADBEEF in DONE, Stall high for 4 cycles then low for 1.
- LB addr 0x103, rdata 0x80123456 → ReadData=0xFFFFFF80; LBU same access → 0x00000080; LHU addr 0x102 → 0x00008012.
- SB addr 0x201, WriteData 0x000000AB → mem_addr 0x200, wstrb 0010, wdata 0xABABABAB, mem_we=1, no WAIT_R visited.
- LW addr 0x102 → no mem_req; AccessErr pulses 1 cycle in DONE; ReadData holds its previous value; Stall high for 1 cycle.
- TIMEOUT_CYCLES=4, gnt never asserted → mem_req high for 4 cycles then drops; AccessErr pulses; FSM returns to IDLE.
- Reset asserted in WAIT_R, then rvalid with 0x12345678 → state IDLE, mem_req=0, ReadData=0, no update from the stray rvalid.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Handshaked data-memory port between the load/store stage and
//             the memory system.
//  Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage: issues one bus transaction per load/store,
//             stalls the core until it completes, returns extended load data.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              AccessErr,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_err;
    logic [15:0] r_cnt;
    logic [31:0] r_rdata;

    logic        w_access;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_err_in;
    logic        w_timeout;
    logic        w_set_err;
    logic        w_capture;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_access   = MemRead | MemWrite;
    // Stores only have signed-size encodings; loads also allow BU/HU.
    assign w_bad_f3   = MemWrite ? (funct3[2] | (funct3[1:0] == 2'b11))
                                 : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
    assign w_misalign = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                        ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));
    assign w_err_in   = w_bad_f3 | w_misalign;
    assign w_timeout  = (r_cnt == c_TO_LAST);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = WriteData;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << ALUResult[1:0];
                    w_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    w_wstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteData[15:0]}};
                end
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        w_byte = mem.mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem.mem_rdata[15:8];
            2'd2:    w_byte = mem.mem_rdata[23:16];
            2'd3:    w_byte = mem.mem_rdata[31:24];
            default: w_byte = mem.mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A grant or read response arriving on the final allowed cycle wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next = w_err_in ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    w_next = r_we ? DONE : WAIT_R;
                end else if (w_timeout) begin
                    w_next    = DONE;
                    w_set_err = 1'b1;
                end
            end
            WAIT_R: begin
                if (mem.mem_rvalid) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else if (w_timeout) begin
                    w_next    = DONE;
                    w_set_err = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_we     <= 1'b0;
            r_addr   <= 30'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_err    <= 1'b0;
            r_cnt    <= 16'd0;
            r_rdata  <= 32'd0;
        end else begin
            if ((r_state == IDLE) && w_access) begin
                r_funct3 <= funct3;
                r_off    <= ALUResult[1:0];
                r_we     <= MemWrite;
                r_addr   <= ALUResult[31:2];
                r_wdata  <= w_wdata;
                r_wstrb  <= w_wstrb;
                r_err    <= w_err_in;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (r_state == IDLE) begin
                r_cnt <= 16'd0;
            end else if ((r_state == REQ) || (r_state == WAIT_R)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_capture) begin
                r_rdata <= w_load;
            end
        end
    end

    assign ReadData      = r_rdata;
    assign Stall         = ((r_state == IDLE) & w_access) | (r_state == REQ) | (r_state == WAIT_R);
    assign AccessErr     = (r_state == DONE) & r_err;
    assign mem.mem_req   = (r_state == REQ);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = {r_addr, 2'b00};
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_TIMEOUT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AccessErr;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(c_TIMEOUT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AccessErr (AccessErr),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_rd    = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        MemRead = 1'b0;
        MemWrite = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = ($urandom % 2 == 0);
        bus.mem_rdata = $urandom;
        #1;
        check("idle_stall", 32'(Stall), 32'd0);
        check("idle_req", 32'(bus.mem_req), 32'd0);
        check("idle_rdata", ReadData, m_rd);
    endtask

    // gnt_wait: REQ cycles before the grant; rv_wait: WAIT_R cycles before rvalid.
    task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                              input logic [31:0] rdata);
        int          nb, total, busy, ncyc, c;
        bit          err, timed_out, in_req, in_wait;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_rd;
        nb        = 1 << f3[1:0];
        err       = (ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 > 3'd2))
                    || ((int'(addr[1:0]) % nb) != 0);
        total     = gnt_wait + 1 + (ld ? rv_wait + 1 : 0);
        timed_out = !err && (total > c_TIMEOUT);
        busy      = (total < c_TIMEOUT) ? total : c_TIMEOUT;
        ncyc      = err ? 1 : 1 + busy;
        exp_rd    = (ld && !err && !timed_out) ? ref_load(f3, addr, rdata) : m_rd;
        exp_strb  = ld ? 4'b0000 : 4'(((1 << nb) - 1) << addr[1:0]);
        case (f3[1:0])
            2'd0:    exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            default: exp_wdata = wd;
        endcase
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            MemRead = ld;
            MemWrite = !ld;
            funct3 = f3;
            ALUResult = addr;
            WriteData = wd;
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = ($urandom % 4 == 0);
            bus.mem_rdata = $urandom;
            c = k - 1;
            in_req  = !err && k >= 1 && k < ncyc && c <= gnt_wait;
            in_wait = !err && k >= 1 && k < ncyc && c > gnt_wait;
            if (in_req) bus.mem_gnt = (c == gnt_wait);
            if (in_wait) begin
                bus.mem_rvalid = ((c - gnt_wait - 1) == rv_wait);
                bus.mem_rdata  = bus.mem_rvalid ? rdata : $urandom;
            end
            #1;
            check("stall", 32'(Stall), 32'(k < ncyc));
            check("mem_req", 32'(bus.mem_req), 32'(in_req));
            check("access_err", 32'(AccessErr), 32'(k == ncyc && (err || timed_out)));
            check("read_data", ReadData, (k == ncyc) ? exp_rd : m_rd);
            if (in_req) begin
                check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                check("mem_we", 32'(bus.mem_we), 32'(!ld));
                check("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_strb));
                if (!ld) check("mem_wdata", bus.mem_wdata, exp_wdata);
            end
        end
        m_rd = exp_rd;
    endtask

    initial begin
        bit          ld;
        logic [2:0]  f3;
        logic [31:0] a;
        int          gw, rw;

        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        funct3 = 3'd0;
        ALUResult = 32'd0;
        WriteData = 32'd0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_err", 32'(AccessErr), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_access(1, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        run_access(1, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80123456);
        run_access(1, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80123456);
        run_access(1, 3'b101, 32'h102, 32'h0, 0, 2, 32'h80123456);
        run_access(1, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80123456);
        run_access(0, 3'b000, 32'h201, 32'h000000AB, 0, 0, 32'h0);
        run_access(0, 3'b001, 32'h202, 32'h1234CDEF, 2, 0, 32'h0);
        run_access(0, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 32'h0);
        run_access(1, 3'b010, 32'h102, 32'h0, 0, 0, 32'h11111111);
        run_access(1, 3'b011, 32'h100, 32'h0, 0, 0, 32'h22222222);
        run_access(0, 3'b100, 32'h100, 32'h5, 0, 0, 32'h0);
        run_access(0, 3'b001, 32'h101, 32'h5, 0, 0, 32'h0);
        run_access(0, 3'b010, 32'h300, 32'h77, c_TIMEOUT - 1, 0, 32'h0);
        run_access(0, 3'b010, 32'h300, 32'h77, c_TIMEOUT, 0, 32'h0);
        run_access(1, 3'b010, 32'h400, 32'h0, 0, c_TIMEOUT - 2, 32'hA5A5A5A5);
        run_access(1, 3'b010, 32'h404, 32'h0, 0, c_TIMEOUT - 1, 32'h5A5A5A5A);
        run_access(1, 3'b010, 32'h408, 32'h0, c_TIMEOUT + 2, 0, 32'h33333333);
        idle_cycle();

        for (int i = 0; i < 150; i++) begin
            ld = ($urandom % 2 == 0);
            if ($urandom % 5 == 0) begin
                f3 = 3'($urandom);
            end else if (ld) begin
                case ($urandom % 5)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom % 3);
            end
            a = $urandom;
            if ($urandom % 4 != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            gw = ($urandom % 8 == 0) ? c_TIMEOUT : int'($urandom_range(0, 3));
            rw = ($urandom % 8 == 0) ? c_TIMEOUT - 1 : int'($urandom_range(0, 3));
            run_access(ld, f3, a, $urandom, gw, rw, $urandom);
            if ($urandom % 3 == 0) idle_cycle();
        end

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        MemRead = 1'b1;
        MemWrite = 1'b0;
        funct3 = 3'b010;
        ALUResult = 32'h100;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        check("wait_stall", 32'(Stall), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        MemRead = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h12345678;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_stall", 32'(Stall), 32'd0);
        check("mid_rst_rdata", ReadData, 32'd0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check("stray_rdata", ReadData, 32'd0);
        check("stray_err", 32'(AccessErr), 32'd0);
        m_rd = 32'd0;
        idle_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
